// File: rtl/irq_dispatch_pkg.sv
// rtl/irq_dispatch_pkg.sv - shared types and constants for the interrupt dispatch stage
package irq_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    REQ,
    SERVICE,
    HOLDOFF
  } state_e;

  localparam int NUM_GRP  = 3;
  localparam int MAX_CHAN = 8;
  localparam int VEC_W    = 6;
  localparam int CNT_W    = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/irq_cand_select.sv
// rtl/irq_cand_select.sv - combinational candidate select: lowest-set-group priority encode plus channel range check
module irq_cand_select
  import irq_dispatch_pkg::*;
(
  input  logic [NUM_GRP-1:0] grp_active_i,
  input  logic [3:0]         chan_idx_i,
  output logic               valid_o,
  output logic [VEC_W-1:0]   cand_o
);

  logic [1:0] grp_id;

  always_comb begin
    grp_id = 2'd0;
    if (grp_active_i[0]) begin
      grp_id = 2'd0;
    end else if (grp_active_i[1]) begin
      grp_id = 2'd1;
    end else if (grp_active_i[2]) begin
      grp_id = 2'd2;
    end
    valid_o = (|grp_active_i) && (chan_idx_i <= 4'(MAX_CHAN));
    cand_o  = {grp_id, chan_idx_i};
  end

endmodule

// File: rtl/irq_dispatch.sv
// rtl/irq_dispatch.sv - interrupt dispatch FSM: stability filter, req/ack/eoi handshake, hold-off, saturating count
// Optional ack timeout enabled by defining IRQ_DISPATCH_TIMEOUT_EN.
module irq_dispatch
  import irq_dispatch_pkg::*;
#(
  parameter int STABLE_CYCLES  = 2,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_GRP-1:0] grp_active,
  input  logic [3:0]         chan_idx,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               busy,
  output logic [CNT_W-1:0]   irq_count,
  output logic               timeout_err
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15 || HOLDOFF_CYCLES < 0 || HOLDOFF_CYCLES > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
    $error("irq_dispatch: parameter out of legal range");
  end

  logic [NUM_GRP-1:0] grp_q;
  logic [3:0]         chan_q;
  logic               cand_valid;
  logic [VEC_W-1:0]   cand;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   cap_q, cap_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [3:0]         stab_q, stab_d;
  logic [3:0]         hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
  logic [7:0]         tcnt_q, tcnt_d;
  logic               terr_q, terr_d;
`endif

  irq_cand_select u_cand_select (
    .grp_active_i (grp_q),
    .chan_idx_i   (chan_q),
    .valid_o      (cand_valid),
    .cand_o       (cand)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q   <= '0;
      chan_q  <= '0;
      state_q <= IDLE;
      cap_q   <= '0;
      vec_q   <= '0;
      stab_q  <= '0;
      hcnt_q  <= '0;
      cnt_q   <= '0;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
      tcnt_q  <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      grp_q   <= grp_active;
      chan_q  <= chan_idx;
      state_q <= state_d;
      cap_q   <= cap_d;
      vec_q   <= vec_d;
      stab_q  <= stab_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    vec_d   = vec_q;
    stab_d  = stab_q;
    hcnt_d  = hcnt_q;
    cnt_d   = cnt_q;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    terr_d  = terr_q;
`endif
    case (state_q)
      IDLE: begin
        if (cand_valid) begin
          if (STABLE_CYCLES == 1) begin
            vec_d   = cand;
            state_d = REQ;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end else begin
            cap_d   = cand;
            stab_d  = 4'd1;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!cand_valid) begin
          state_d = IDLE;
        end else if (cand != cap_q) begin
          // A changed candidate restarts the stability window rather than aborting.
          cap_d  = cand;
          stab_d = 4'd1;
        end else if ((5'(stab_q) + 5'd1) == 5'(STABLE_CYCLES)) begin
          vec_d   = cap_q;
          state_d = REQ;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d = SERVICE;
          cnt_d   = sat_inc(cnt_q);
`ifdef IRQ_DISPATCH_TIMEOUT_EN
        end else if (tcnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          terr_d = 1'b1;
          if (HOLDOFF_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            hcnt_d  = 4'(HOLDOFF_CYCLES);
          end
        end else begin
          tcnt_d = tcnt_q + 8'd1;
`endif
        end
      end
      SERVICE: begin
        if (irq_eoi) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            hcnt_d  = 4'(HOLDOFF_CYCLES);
          end
        end
      end
      HOLDOFF: begin
        hcnt_d = hcnt_q - 4'd1;
        if (hcnt_q <= 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign irq_req   = (state_q == REQ);
  assign busy      = (state_q != IDLE);
  assign irq_vec   = vec_q;
  assign irq_count = cnt_q;
`ifdef IRQ_DISPATCH_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
